// File: rtl/tx_arb_if.sv
// Handshake bundle between the packet builders, tx_arb and the 100M MII TX MAC.
// master = arbiter side, slave = requesters plus MAC side.
interface tx_arb_if #(
    parameter int NSRC = 2
);
    logic [NSRC-1:0]   req_vld;
    logic [NSRC-1:0]   req_eof;
    logic [4*NSRC-1:0] req_dat;
    logic [NSRC-1:0]   req_ack;
    logic              mac_vld;
    logic              mac_eof;
    logic [3:0]        mac_dat;
    logic              mac_ack;
    logic [1:0]        grant;
    logic              busy;

    modport master (
        input  req_vld, req_eof, req_dat, mac_ack,
        output req_ack, mac_vld, mac_eof, mac_dat, grant, busy
    );

    modport slave (
        output req_vld, req_eof, req_dat, mac_ack,
        input  req_ack, mac_vld, mac_eof, mac_dat, grant, busy
    );
endinterface

// File: rtl/tx_arb.sv
// Round-robin whole-frame arbiter feeding one MII TX MAC; TX_ARB_PAD_EN enables min-length padding.
// Latency: grant 1 cycle after a request is seen idle; nibble data/ack paths are combinational.
// Backpressure: mac_ack is passed straight to the granted requester; others hold until the next idle.
module tx_arb #(
    parameter int NSRC = 2
) (
    input  logic     clk_tx,
    input  logic     rst,
    tx_arb_if.master bus
);
    typedef enum logic [1:0] {FLUSH, IDLE, DATA, PAD} state_t;

    localparam logic [6:0] NCNT_LAST = 7'd119;
    localparam logic [6:0] NCNT_MAX  = 7'd120;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      grant_q;
    logic [1:0]      ptr_q;
    logic [1:0]      pick;
    logic [2:0]      cand;
    logic [6:0]      ncnt_q;
    logic            any_req;
    logic            src_eof;
    logic            pad_need;
    logic            frame_end;
    logic [3:0]      vld4;
    logic [3:0]      eof4;
    logic [3:0][3:0] dat4;
    logic [NSRC-1:0] ack;
    logic            mac_vld;
    logic            mac_eof;
    logic [3:0]      mac_dat;

    // Zero-extend to four sources so a 2-bit grant can index any build.
    assign vld4    = 4'(bus.req_vld);
    assign eof4    = 4'(bus.req_eof);
    assign dat4    = 16'(bus.req_dat);
    assign src_eof = eof4[grant_q];

`ifdef TX_ARB_PAD_EN
    assign pad_need = (ncnt_q < NCNT_LAST);
`else
    assign pad_need = 1'b0;
`endif

    assign frame_end = bus.mac_ack &&
                       (((state == DATA) && src_eof && !pad_need) ||
                        ((state == PAD) && (ncnt_q == NCNT_LAST)));

    // Walk from farthest to nearest so the source closest after ptr wins.
    always_comb begin
        pick    = ptr_q;
        any_req = 1'b0;
        cand    = '0;
        for (int k = NSRC; k >= 1; k--) begin
            cand = 3'(ptr_q) + 3'(k);
            if (cand >= 3'(NSRC)) begin
                cand = cand - 3'(NSRC);
            end
            if (vld4[cand[1:0]]) begin
                pick    = cand[1:0];
                any_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_tx) begin
        if (rst) begin
            state <= FLUSH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FLUSH: state_nxt = IDLE;
            IDLE:  if (any_req) state_nxt = DATA;
            DATA:  if (bus.mac_ack && src_eof) state_nxt = pad_need ? PAD : IDLE;
            PAD:   if (bus.mac_ack && (ncnt_q == NCNT_LAST)) state_nxt = IDLE;
            default: state_nxt = FLUSH;
        endcase
    end

    always_comb begin
        mac_vld = 1'b0;
        mac_eof = 1'b0;
        mac_dat = 4'd0;
        ack     = '0;
        case (state)
            FLUSH: mac_eof = 1'b1;
            DATA: begin
                mac_vld = 1'b1;
                mac_dat = dat4[grant_q];
                mac_eof = src_eof && !pad_need;
                for (int i = 0; i < NSRC; i++) begin
                    ack[i] = bus.mac_ack && (grant_q == 2'(i));
                end
            end
            PAD: begin
                mac_vld = 1'b1;
                mac_eof = (ncnt_q == NCNT_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_tx) begin
        if (rst) begin
            grant_q <= 2'd0;
            ptr_q   <= 2'(NSRC - 1);
            ncnt_q  <= 7'd0;
        end else begin
            if ((state == IDLE) && any_req) begin
                grant_q <= pick;
                ncnt_q  <= 7'd0;
            end else if (((state == DATA) || (state == PAD)) && bus.mac_ack &&
                         (ncnt_q != NCNT_MAX)) begin
                ncnt_q <= ncnt_q + 7'd1;
            end
            if (frame_end) begin
                ptr_q <= grant_q;
            end
        end
    end

    assign bus.req_ack = ack;
    assign bus.mac_vld = mac_vld;
    assign bus.mac_eof = mac_eof;
    assign bus.mac_dat = mac_dat;
    assign bus.grant   = grant_q;
    assign bus.busy    = (state == DATA) || (state == PAD);
endmodule

// File: tb/tb_tx_arb.sv
// Bench for tx_arb: queued requesters, behavioural MII MAC and a scoreboard monitor.
// Expected frames (padded when TX_ARB_PAD_EN is defined) are queued at send time.
module tb_tx_arb;
    localparam int NSRC = 4;
    localparam int MIN_NIB = 120;
`ifdef TX_ARB_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    logic clk_tx = 1'b0;
    logic rst = 1'b1;

    tx_arb_if #(.NSRC(NSRC)) bus ();
    tx_arb #(.NSRC(NSRC)) dut (.clk_tx(clk_tx), .rst(rst), .bus(bus));

    always #5 clk_tx = ~clk_tx;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    logic [3:0] src_q    [NSRC][$];
    int         src_len  [NSRC][$];
    int         src_pos  [NSRC];
    int         ack_cnt  [NSRC];
    logic [3:0] exp_q    [NSRC][$];
    int         exp_len  [NSRC][$];
    int         exp_slen [NSRC][$];

    task automatic send(input int s, input int len);
        int plen;
        logic [3:0] n;
        plen = len;
        if (PAD_ON && len < MIN_NIB) plen = MIN_NIB;
        for (int i = 0; i < plen; i++) begin
            n = (i < len) ? 4'($urandom) : 4'd0;
            if (i < len) src_q[s].push_back(n);
            exp_q[s].push_back(n);
        end
        src_len[s].push_back(len);
        exp_len[s].push_back(plen);
        exp_slen[s].push_back(len);
    endtask

    task automatic flush_sources();
        for (int s = 0; s < NSRC; s++) begin
            src_q[s].delete();
            src_len[s].delete();
            exp_q[s].delete();
            exp_len[s].delete();
            exp_slen[s].delete();
            src_pos[s] = 0;
        end
    endtask

    task automatic drive();
        logic [NSRC-1:0]   v;
        logic [NSRC-1:0]   e;
        logic [4*NSRC-1:0] d;
        v = '0;
        e = '0;
        d = '0;
        for (int s = 0; s < NSRC; s++) begin
            if (src_len[s].size() > 0) begin
                v[s] = 1'b1;
                e[s] = (src_pos[s] == src_len[s][0] - 1);
                d[4*s +: 4] = src_q[s][0];
            end
        end
        bus.req_vld = v;
        bus.req_eof = e;
        bus.req_dat = d;
    endtask

    // Requesters: consume a nibble for every ack seen before the edge.
    initial begin : driver
        logic [NSRC-1:0] ack_s;
        logic            rst_s;
        logic [3:0]      drop;
        drive();
        forever begin
            @(negedge clk_tx);
            ack_s = bus.req_ack;
            rst_s = rst;
            @(posedge clk_tx);
            #1;
            if (!rst_s) begin
                for (int s = 0; s < NSRC; s++) begin
                    if (ack_s[s]) begin
                        if (src_len[s].size() == 0) begin
                            check("spurious_ack", 1, 0);
                        end else begin
                            drop = src_q[s].pop_front();
                            src_pos[s]++;
                            ack_cnt[s]++;
                            if (src_pos[s] == src_len[s][0]) begin
                                src_len[s].delete(0);
                                src_pos[s] = 0;
                            end
                        end
                    end
                end
            end
            #2;
            drive();
        end
    end

    typedef enum int {M_IDLE, M_PRE, M_DATA, M_IPG} mac_st_t;
    mac_st_t mst = M_DATA;
    int      mcnt = 0;

    // MAC: 16 preamble cycles, ack while in data, 12-cycle FCS/IPG after eof.
    initial begin : mac_model
        logic v;
        logic e;
        logic r;
        bus.mac_ack = 1'b1;
        forever begin
            @(negedge clk_tx);
            v = bus.mac_vld;
            e = bus.mac_eof;
            r = rst;
            @(posedge clk_tx);
            #1;
            if (!r) begin
                case (mst)
                    M_IDLE: if (v) begin mst = M_PRE; mcnt = 16; end
                    M_PRE:  begin mcnt--; if (mcnt == 0) mst = M_DATA; end
                    M_DATA: if (e) begin mst = M_IPG; mcnt = 12; end
                    default: begin mcnt--; if (mcnt == 0) mst = M_IDLE; end
                endcase
            end
            bus.mac_ack = (mst == M_DATA);
        end
    end

    bit         mon_act = 1'b0;
    bit         pend = 1'b0;
    bit         gap_chk = 1'b0;
    int         pend_g;
    int         last_g = NSRC - 1;
    int         idx;
    int         cur_len;
    int         cur_slen;
    int         last_flen;
    logic [3:0] cur[$];
    int         glog[$];

    function automatic int rr(input int last, input logic [NSRC-1:0] v);
        for (int k = 1; k <= NSRC; k++) begin
            int j;
            j = (last + k) % NSRC;
            if (v[j]) return j;
        end
        return 0;
    endfunction

    initial begin : monitor
        forever begin
            @(negedge clk_tx);
            if (rst) begin
                mon_act = 1'b0;
                pend    = 1'b0;
                gap_chk = 1'b0;
                last_g  = NSRC - 1;
                cur.delete();
            end else begin
                check("ack_onehot", int'($countones(bus.req_ack) <= 1), 1);
                if (gap_chk) begin
                    check("gap_after_eof", bus.mac_vld, 0);
                    gap_chk = 1'b0;
                end
                if (pend) begin
                    pend = 1'b0;
                    check("vld_rise", bus.mac_vld, 1);
                    check("grant", bus.grant, pend_g);
                    glog.push_back(int'(bus.grant));
                    last_g = pend_g;
                    if (exp_len[pend_g].size() == 0) begin
                        check("exp_frame", 0, 1);
                    end else begin
                        cur_len  = exp_len[pend_g].pop_front();
                        cur_slen = exp_slen[pend_g].pop_front();
                        cur.delete();
                        for (int i = 0; i < cur_len; i++) cur.push_back(exp_q[pend_g].pop_front());
                        idx     = 0;
                        mon_act = 1'b1;
                    end
                end else if (!mon_act && !bus.busy && !bus.mac_vld && !bus.mac_eof &&
                             bus.req_vld != '0) begin
                    pend   = 1'b1;
                    pend_g = rr(last_g, bus.req_vld);
                end
                if (mon_act && bus.mac_vld && bus.mac_ack) begin
                    check("nib_dat", bus.mac_dat, cur[idx]);
                    check("nib_eof", bus.mac_eof, int'(idx == cur_len - 1));
                    check("nib_ack", bus.req_ack, (idx < cur_slen) ? (1 << last_g) : 0);
                    idx++;
                    if (bus.mac_eof || idx == cur_len) begin
                        mon_act   = 1'b0;
                        gap_chk   = 1'b1;
                        last_flen = idx;
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_tx);
            #2;
        end
    endtask

    function automatic bit pending();
        for (int s = 0; s < NSRC; s++) if (src_len[s].size() > 0) return 1'b1;
        return mon_act || pend;
    endfunction

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (n < budget && pending()) begin
            cyc(1);
            n++;
        end
        check("drain", int'(n < budget), 1);
        cyc(24);
    endtask

    task automatic clear_logs();
        for (int s = 0; s < NSRC; s++) ack_cnt[s] = 0;
        glog.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush_sources();
        cyc(3);
        rst = 1'b0;
        cyc(24);
        clear_logs();
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : main
        int n;
        int lt[8];
        int s;
        int len;
        int left;
        lt = '{1, 2, 20, 118, 119, 120, 121, 127};
        cyc(4);
        @(negedge clk_tx);
        check("rst_vld", bus.mac_vld, 0);
        check("rst_eof", bus.mac_eof, 1);
        check("rst_dat", bus.mac_dat, 0);
        check("rst_ack", bus.req_ack, 0);
        check("rst_grant", bus.grant, 0);
        check("rst_busy", bus.busy, 0);
        cyc(1);
        rst = 1'b0;
        @(negedge clk_tx);
        check("flush_vld", bus.mac_vld, 0);
        check("flush_eof", bus.mac_eof, 1);
        @(negedge clk_tx);
        check("idle_eof", bus.mac_eof, 0);
        check("idle_vld", bus.mac_vld, 0);
        check("mac_released", int'(mst == M_DATA), 0);
        cyc(24);
        clear_logs();

        send(0, 128);
        wait_done(2000);
        check("single_acks", ack_cnt[0], 128);
        check("single_grant", bus.grant, 0);
        check("single_frames", glog.size(), 1);

        do_reset();
        send(0, 128); send(1, 128); send(0, 128); send(1, 128);
        wait_done(4000);
        check("alt_frames", glog.size(), 4);
        for (int i = 0; i < glog.size() && i < 4; i++) check("alt_grant", glog[i], i % 2);

        do_reset();
        send(1, 16);
        wait_done(1000);
        glog.delete();
        send(1, 24); send(3, 24);
        wait_done(2000);
        check("ptr1_frames", glog.size(), 2);
        if (glog.size() == 2) begin
            check("ptr1_first", glog[0], 3);
            check("ptr1_second", glog[1], 1);
        end

        do_reset();
        send(2, 20);
        wait_done(1000);
        check("short_acks", ack_cnt[2], 20);
        check("short_len", last_flen, PAD_ON ? MIN_NIB : 20);

        do_reset();
        send(0, 128);
        n = 0;
        while (ack_cnt[0] < 50 && n < 1000) begin
            cyc(1);
            n++;
        end
        check("abort_at50", ack_cnt[0], 50);
        rst = 1'b1;
        flush_sources();
        @(negedge clk_tx);
        @(negedge clk_tx);
        check("abort_vld", bus.mac_vld, 0);
        check("abort_eof", bus.mac_eof, 1);
        cyc(3);
        rst = 1'b0;
        cyc(24);
        clear_logs();
        send(0, 40); send(2, 40);
        wait_done(2000);
        check("post_abort_frames", glog.size(), 2);
        if (glog.size() > 0) check("post_abort_grant", glog[0], 0);
        check("post_abort_acks", ack_cnt[0], 40);

        do_reset();
        for (int i = 0; i < 36; i++) begin
            s   = $urandom_range(0, NSRC - 1);
            len = (i < 8) ? lt[i] : $urandom_range(1, 140);
            send(s, len);
            cyc($urandom_range(0, 150));
        end
        wait_done(30000);
        left = 0;
        for (int k = 0; k < NSRC; k++) left += exp_len[k].size();
        check("rand_leftover", left, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tx_arb.md
# tx_arb

Round-robin frame arbiter that shares the single 100M MII transmit MAC between `NSRC` nibble-stream requesters. It grants the MAC to one requester for one whole frame and forwards that requester's nibbles using the MAC's valid/ack/eof handshake. When frames end short, it optionally pads them to the Ethernet minimum length. It sits between the packet builders and the TX MAC in the `clk_tx` domain.

## Interface
- `NSRC`, default 2: number of requesters, 2..4.
- `clk_tx`  in  1  MII transmit clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_vld`  in  NSRC  per-source frame request; must stay high from first nibble through the eof nibble.
- `req_eof`  in  NSRC  per-source last-nibble flag.
- `req_dat`  in  4*NSRC  per-source nibble; source i uses bits [4i+3:4i].
- `req_ack`  out  NSRC  per-source nibble accept; at most one bit high.
- `mac_vld`  out  1  to MAC tx_vld.
- `mac_eof`  out  1  to MAC tx_eof.
- `mac_dat`  out  4  to MAC tx_dat.
- `mac_ack`  in  1  from MAC tx_ack; high while the MAC is in its data state.
- `grant`  out  2  index of the current or last granted source.
- `busy`  out  1  high in DATA or PAD.

## Operation
- States: FLUSH, IDLE, DATA, PAD.
- FLUSH is the reset state. Outputs: `mac_vld`=0, `mac_eof`=1, `mac_dat`=0, `req_ack`=0. It lasts exactly one cycle after `rst` deasserts, then goes to IDLE. The forced eof releases a MAC left in its data state by a mid-frame reset; the MAC ignores eof in all other states.
- IDLE: `mac_vld`=0. If any `req_vld` bit is high, pick the first high bit searching from `ptr+1` modulo NSRC. Register it into `grant`, clear `ncnt`, and go to DATA. With no requests, stay in IDLE.
- DATA:
  - `mac_vld`=1, `mac_dat`=`req_dat[grant]`.
  - `req_ack[grant]` = `mac_ack`.
  - A nibble transfers on a cycle where `mac_ack` is high.
  - Each transfer increments `ncnt`, saturating at 120.
- Eof in DATA when the transfer has `req_eof[grant]`=1:
  - `mac_eof` = `req_eof[grant]` unless padding is required (see Configuration).
  - If forwarded: on transfer, set `ptr`←`grant` and go to IDLE.
  - If padding is required: `mac_eof`=0, the source's eof is still acked, and the next state is PAD.
- PAD:
  - `mac_vld`=1, `mac_dat`=0, `req_ack`=0.
  - Each `mac_ack` cycle increments `ncnt`.
  - `mac_eof`=1 when `ncnt`=119; on that transfer, set `ptr`←`grant` and go to IDLE.
- `req_vld[grant]` dropping in DATA without eof is a protocol violation. The arbiter keeps forwarding `req_dat`; the bench flags the violation.
- A request arriving at a non-granted source during DATA/PAD is held by that source and is arbitrated on the next IDLE.
- `ptr` resets to NSRC-1, so source 0 wins the first arbitration.
- `ncnt` is 7 bits. 120 nibbles = 60 bytes, excluding FCS.

## Timing
- Reset values: `mac_vld`=0, `mac_eof`=1, `mac_dat`=0, `req_ack`=0, `grant`=0, `busy`=0.
- `mac_vld` rises 1 cycle after a request is seen in IDLE. The MAC then spends 16 cycles in preamble/SFD before the first `mac_ack`.
- The `req_dat`→`mac_dat` and `mac_ack`→`req_ack` paths are combinational. There is no added latency per nibble.
- After an eof transfer, `mac_vld` is low for at least 1 cycle (IDLE) before the next grant.
  - A new `mac_vld` may rise during the MAC's FCS/IPG countdown. The MAC starts the next preamble only when it returns to idle.
- `rst` asserted in any state: next state is FLUSH, `ncnt` and `ptr` are reinitialised, and any partial frame is abandoned.

## Configuration
- `TX_ARB_PAD_EN` defined:
  - Padding is required when eof arrives with `ncnt`<119 (frame shorter than 120 nibbles), and the PAD state is used.
  - `mac_eof` on an eof transfer in DATA is `req_eof[grant]` && `ncnt`>=119.
- `TX_ARB_PAD_EN` undefined:
  - No PAD state and no padding.
  - `ncnt` is still maintained.
  - `mac_eof` = `req_eof[grant]` in DATA, and the frame is forwarded at its original length.

## Test plan
- Reset release with MAC model stuck in data state → 1 cycle of `mac_eof`=1 with `mac_vld`=0, then IDLE; MAC model returns to idle after FCS/IPG.
- Source 0 alone sends a 128-nibble frame → `mac_vld` high 1 cycle after `req_vld`, 128 `req_ack[0]` pulses, `mac_eof` on nibble 128, data matches; `grant`=0.
- Sources 0 and 1 both request continuously with 128-nibble frames, NSRC=2 → grants alternate 0,1,0,1 over 4 frames; `req_ack` never high on both bits.
- NSRC=4 with sources 1 and 3 requesting and `ptr`=1 → source 3 granted first, then source 1.
- `TX_ARB_PAD_EN` on, source sends a 20-nibble frame → source acked 20 times, `mac_eof`=0 on nibble 20, 100 zero nibbles follow, `mac_eof` on nibble 120. With the macro off → `mac_eof` on nibble 20.
- `rst` asserted at nibble 50 of a frame → FLUSH next cycle, `mac_vld`=0, `mac_eof`=1; a new request after release is granted to source 0 and completes normally.
